// File: rtl/recv_img_pkg.sv
// Shared types for the UART image receiver: top FSM states, UART receiver states, image geometry.
package recv_img_pkg;
  typedef enum logic {IDLE = 1'b0, RECEIVING = 1'b1} recv_state_t;
  typedef enum logic [1:0] {RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3} rx_state_t;
  localparam int IMG_W = 64;
  localparam int IMG_H = 64;
endpackage

// File: rtl/recv_img_uart_rx.sv
// 8N1 UART receiver, LSB first, mid-bit sampling; valid_o/ferr_o are one-cycle pulses after the stop sample.
module uart_rx
  import recv_img_pkg::*;
#(
  parameter int CLOCKS_PER_BAUD = 50
) (
  input  logic       clk,
  input  logic       rst_in_n,
  input  logic       rx_sync,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       ferr_o
);
  localparam int CW = $clog2(CLOCKS_PER_BAUD);
  localparam logic [CW-1:0] HALF = CW'(CLOCKS_PER_BAUD / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLOCKS_PER_BAUD - 1);

  rx_state_t      state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           valid_q, valid_d;
  logic           ferr_q, ferr_d;

  always_ff @(posedge clk or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rx_sync) state_d = RX_START;
      end
      RX_START: begin
        // Half a bit in: a line already back high was a glitch, not a start bit.
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          shift_d = {rx_sync, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = RX_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          valid_d = rx_sync;
          ferr_d  = !rx_sync;
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign data_o  = shift_q;
  assign valid_o = valid_q;
  assign ferr_o  = ferr_q;
endmodule

// File: rtl/recv_img.sv
// Receives an image over UART and writes it into BRAM addresses 0..BRAM_LENGTH-1 after each arm pulse.
// Optional idle-abandon timer enabled by defining RECV_IMG_TIMEOUT_EN.
module recv_img
  import recv_img_pkg::*;
#(
  parameter int CLOCKS_PER_BAUD = 50,
  parameter int BRAM_LENGTH     = IMG_W * IMG_H,
  parameter int ADDR_W          = 14,
  parameter int TIMEOUT_CYCLES  = 500000
) (
  input  logic              clk,
  input  logic              rst_in_n,
  input  logic              rx,
  input  logic              arm,
  output logic [ADDR_W-1:0] address,
  output logic [7:0]        data_out,
  output logic              we,
  output logic              busy,
  output logic              img_received,
  output logic              frame_err,
  output logic              timeout,
  output logic [1:0]        out_state
);
  if (CLOCKS_PER_BAUD < 8)                 $error("CLOCKS_PER_BAUD must be >= 8");
  if (BRAM_LENGTH > (1 << ADDR_W))         $error("BRAM_LENGTH does not fit in ADDR_W");
  if (TIMEOUT_CYCLES < 1)                  $error("TIMEOUT_CYCLES must be >= 1");

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BRAM_LENGTH - 1);

  // Reset asserts asynchronously but releases in step with clk.
  logic [1:0] rst_sync_q;
  logic       rst_n;
  always_ff @(posedge clk or negedge rst_in_n) begin
    if (!rst_in_n) rst_sync_q <= 2'b00;
    else           rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  logic rx_meta_q, rx_sync_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  logic [7:0] rx_data;
  logic       rx_valid, rx_ferr;
  uart_rx #(.CLOCKS_PER_BAUD(CLOCKS_PER_BAUD)) u_uart_rx (
    .clk     (clk),
    .rst_in_n(rst_n),
    .rx_sync (rx_sync_q),
    .data_o  (rx_data),
    .valid_o (rx_valid),
    .ferr_o  (rx_ferr)
  );

  recv_state_t       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              we_q, we_d;
  logic              img_q, img_d;
  logic              ferr_q, ferr_d;
  logic              tmo_q, tmo_d;
  logic              tmo_hit;

`ifdef RECV_IMG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;

  // Count only once an image is under way; an armed but untouched receiver waits forever.
  always_comb begin
    tcnt_d = '0;
    if (state_q == RECEIVING) begin
      if (rx_valid)                    tcnt_d = TW'(1);
      else if (addr_q != '0 || we_q)   tcnt_d = tcnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tcnt_q <= '0;
    else        tcnt_q <= tcnt_d;
  end

  assign tmo_hit = (tcnt_q == TW'(TIMEOUT_CYCLES)) && !rx_valid && !we_q;
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      img_q   <= 1'b0;
      ferr_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      img_q   <= img_d;
      ferr_q  <= ferr_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    img_d   = 1'b0;
    ferr_d  = ferr_q;
    tmo_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (arm) begin
          state_d = RECEIVING;
          addr_d  = '0;
          ferr_d  = 1'b0;
        end
      end
      RECEIVING: begin
        if (rx_valid) begin
          we_d   = 1'b1;
          data_d = rx_data;
        end
        if (rx_ferr) ferr_d = 1'b1;
        if (we_q) begin
          if (addr_q == LAST_ADDR) begin
            img_d   = 1'b1;
            addr_d  = '0;
            state_d = IDLE;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end else if (tmo_hit) begin
          tmo_d   = 1'b1;
          addr_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign address      = addr_q;
  assign data_out     = data_q;
  assign we           = we_q;
  assign busy         = (state_q == RECEIVING);
  assign img_received = img_q;
  assign frame_err    = ferr_q;
  assign timeout      = tmo_q;
  assign out_state    = {1'b0, state_q};
endmodule

// File: tb/tb_recv_img.sv
// Randomized bench for recv_img: a transaction-level image model feeds an expected-write queue checked by a monitor.
module tb_recv_img;
  localparam int CPB = 50;
  localparam int LEN = 16;
  localparam int AW  = 14;
  localparam int TMO = 2000;

  logic          clk = 1'b0;
  logic          rst_in_n = 1'b0;
  logic          rx = 1'b1;
  logic          arm = 1'b0;
  logic [AW-1:0] address;
  logic [7:0]    data_out;
  logic          we, busy, img_received, frame_err, timeout;
  logic [1:0]    out_state;

  always #5 clk = ~clk;

  recv_img #(.CLOCKS_PER_BAUD(CPB), .BRAM_LENGTH(LEN), .ADDR_W(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_in_n(rst_in_n), .rx(rx), .arm(arm),
    .address(address), .data_out(data_out), .we(we), .busy(busy),
    .img_received(img_received), .frame_err(frame_err), .timeout(timeout), .out_state(out_state)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  exp_img = 0;
  int  act_img = 0;
  int  cyc = 0;
  int  last_we_cyc = 0;
  bit  m_armed = 1'b0;
  int  m_idx = 0;
  bit  m_ferr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops an expected write for every we and checks the completion pulse.
  initial begin
    wr_t e;
    bit  prev_last;
    prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_in_n) begin
        prev_last = 1'b0;
      end else begin
        if (prev_last) begin
          check("img_after_last_we", img_received, 1);
          check("busy_after_img", busy, 0);
        end else if (img_received) begin
          check("spurious_img_received", img_received, 0);
        end
        if (img_received) act_img++;
`ifndef RECV_IMG_TIMEOUT_EN
        if (timeout) check("timeout_disabled", timeout, 0);
`endif
        prev_last = 1'b0;
        if (we) begin
          last_we_cyc = cyc;
          if (exp_q.size() == 0) begin
            check("unexpected_we", we, 0);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", address, e.a);
            check("wr_data", data_out, e.d);
            prev_last = (e.a == AW'(LEN - 1));
          end
        end
      end
    end
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted, got %0d cycles expected fewer", cyc);
    $fatal(1, "watchdog");
  end

  task automatic m_arm();
    @(negedge clk) arm = 1'b1;
    @(negedge clk) arm = 1'b0;
    if (!m_armed) begin
      m_armed = 1'b1;
      m_idx   = 0;
      m_ferr  = 1'b0;
    end
  endtask

  task automatic uart_bits(input logic [7:0] b, input bit good);
    @(negedge clk) rx = 1'b0;
    repeat (CPB - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    if (good) begin
      rx = 1'b1;
      repeat (CPB) @(negedge clk);
    end else begin
      rx = 1'b0;
      repeat (35) @(negedge clk);
      rx = 1'b1;
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good);
    if (m_armed && good) begin
      exp_q.push_back({AW'(m_idx), b});
      m_idx++;
      if (m_idx == LEN) begin
        m_idx   = 0;
        m_armed = 1'b0;
        exp_img++;
      end
    end
    if (m_armed && !good) m_ferr = 1'b1;
    uart_bits(b, good);
    repeat ($urandom_range(0, 10)) @(negedge clk);
  endtask

  task automatic finish_image();
    for (int k = 0; k < 64 && m_armed; k++)
      send_byte(8'($urandom), $urandom_range(0, 7) != 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_address", address, 0);
    check("rst_data_out", data_out, 0);
    check("rst_we", we, 0);
    check("rst_busy", busy, 0);
    check("rst_img_received", img_received, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_timeout", timeout, 0);
    check("rst_out_state", out_state, 0);
    rst_in_n = 1'b1;
    repeat (5) @(negedge clk);

    // Full image of 0x00..0x0F.
    m_arm();
    check("busy_armed", busy, 32'(m_armed));
    check("out_state_armed", out_state, 32'(m_armed));
    for (int i = 0; i < LEN; i++) send_byte(8'(i), 1'b1);
    check("busy_after_image", busy, 32'(m_armed));

    // Byte before arm is ignored.
    send_byte(8'h55, 1'b1);
    m_arm();
    send_byte(8'hAA, 1'b1);
    check("addr_after_aa", address, 32'(m_idx));
    finish_image();

    // Bad stop bit: dropped, sticky error, next byte reuses the address.
    m_arm();
    send_byte(8'hA5, 1'b0);
    check("frame_err_set", frame_err, 32'(m_ferr));
    check("addr_after_ferr", address, 32'(m_idx));
    send_byte(8'h3C, 1'b1);
    finish_image();
    check("frame_err_sticky", frame_err, 32'(m_ferr));

    // Arm clears frame_err; a short glitch and a second arm change nothing.
    m_arm();
    check("frame_err_cleared", frame_err, 32'(m_ferr));
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b1);
    @(negedge clk) rx = 1'b0;
    repeat (10) @(negedge clk);
    rx = 1'b1;
    repeat (100) @(negedge clk);
    check("addr_after_glitch", address, 32'(m_idx));
    m_arm();
    check("addr_after_rearm", address, 32'(m_idx));
    finish_image();

    // Reset in the middle of byte 5.
    m_arm();
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b1);
    @(negedge clk) rx = 1'b0;
    repeat (CPB + CPB / 2 + 20) @(negedge clk);
    #2 rst_in_n = 1'b0;
    #1;
    check("async_rst_address", address, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_we", we, 0);
    check("async_rst_data_out", data_out, 0);
    check("async_rst_out_state", out_state, 0);
    check("writes_pending_at_reset", exp_q.size(), 0);
    m_armed = 1'b0;
    m_idx   = 0;
    m_ferr  = 1'b0;
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst_in_n = 1'b1;
    repeat (5) @(negedge clk);
    m_arm();
    for (int i = 0; i < LEN; i++) send_byte(8'($urandom), 1'b1);

`ifdef RECV_IMG_TIMEOUT_EN
    begin
      int waited;
      m_arm();
      for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b1);
      waited = 0;
      while (!timeout && waited < 3 * TMO) begin
        @(negedge clk);
        waited++;
      end
      check("timeout_seen", timeout, 1);
      check("timeout_delay", cyc - last_we_cyc, TMO);
      m_armed = 1'b0;
      m_idx   = 0;
      @(negedge clk);
      check("busy_after_timeout", busy, 32'(m_armed));
      m_arm();
      for (int i = 0; i < 2; i++) send_byte(8'($urandom), 1'b1);
    end
`endif

    repeat (50) @(negedge clk);
    check("writes_drained", exp_q.size(), 0);
    check("img_received_count", act_img, exp_img);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
